// File: rtl/display_scanner.sv
// ---------------------------------------------------------------------------
// display_scanner
//   Drives a 4-digit seven-segment display one digit at a time. Each digit
//   owns a scan slot of SCAN_DIV clocks. The first BLANK_CYCLES clocks of
//   every slot keep all digits dark, so the previous pattern cannot ghost
//   onto the next digit. The pattern shown in a slot is latched at the slot
//   start and held until that digit comes round again.
//
//   Segment patterns are packed {A,B,C,D,E,F,G}. Digit order:
//   0 = sum low, 1 = sum high, 2 = prev low, 3 = prev high.
//
// Parameters
//   SCAN_DIV      clocks per digit slot (>= 2)
//   BLANK_CYCLES  dark clocks at the start of each slot (0..SCAN_DIV-1)
//   ACTIVE_LOW    1: An/Seg low = on (common anode), 0: high = on
//
// Ports
//   Clk         system clock, rising edge
//   Rst         asynchronous reset, active high
//   En          scan enable; low keeps the display dark and clears the scan
//   Seg0..Seg3  digit patterns, already in pad polarity
//   Seg         segment bus to the pads
//   An          digit enables, one-hot in the active polarity when lit
//   Digit_sel   index of the current slot
//   Frame_tick  one-cycle pulse on the last clock of slot 3
// ---------------------------------------------------------------------------
module display_scanner #(
    parameter int unsigned SCAN_DIV     = 50000,
    parameter int unsigned BLANK_CYCLES = 500,
    parameter bit          ACTIVE_LOW   = 1'b1
) (
    input  logic       Clk,
    input  logic       Rst,
    input  logic       En,
    input  logic [6:0] Seg0,
    input  logic [6:0] Seg1,
    input  logic [6:0] Seg2,
    input  logic [6:0] Seg3,
    output logic [6:0] Seg,
    output logic [3:0] An,
    output logic [1:0] Digit_sel,
    output logic       Frame_tick
);

    localparam int unsigned   CW       = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(SCAN_DIV - 1);
    localparam logic [3:0]    AN_OFF   = ACTIVE_LOW ? 4'hF : 4'h0;
    localparam logic [6:0]    SEG_OFF  = ACTIVE_LOW ? 7'h7F : 7'h00;

    logic [CW-1:0] cnt, cnt_next;
    logic [1:0]    dig, dig_next;
    logic [6:0]    seg_lat, seg_lat_next;
    logic          running, running_next;
    logic          in_blank;
    logic [3:0]    one_hot;
    logic [3:0]    an_next;
    logic [6:0]    seg_next;
    logic          frame_next;

    // Scan position and latched pattern for the coming cycle. 'running'
    // remembers whether the previous cycle was already scanning, so that the
    // first enabled cycle after reset or after En was low starts cleanly at
    // slot 0, count 0, and loads a fresh pattern for digit 0.
    always_comb begin
        cnt_next     = cnt;
        dig_next     = dig;
        seg_lat_next = seg_lat;
        running_next = running;

        if (!En) begin
            cnt_next     = '0;
            dig_next     = 2'd0;
            running_next = 1'b0;
        end else if (!running) begin
            cnt_next     = '0;
            dig_next     = 2'd0;
            running_next = 1'b1;
        end else if (cnt == CNT_LAST) begin
            cnt_next = '0;
            dig_next = dig + 2'd1;
        end else begin
            cnt_next = cnt + CW'(1);
        end

        // A new slot begins: freeze this digit's pattern for the whole slot.
        if (En && (cnt_next == '0)) begin
            case (dig_next)
                2'd0:    seg_lat_next = Seg0;
                2'd1:    seg_lat_next = Seg1;
                2'd2:    seg_lat_next = Seg2;
                default: seg_lat_next = Seg3;
            endcase
        end
    end

    // With no dead time the comparison would be constant, so it is only
    // built when a blank window actually exists.
    generate
        if (BLANK_CYCLES == 0) begin : g_no_blank
            assign in_blank = 1'b0;
        end else begin : g_blank
            assign in_blank = (32'(cnt_next) < BLANK_CYCLES);
        end
    endgenerate

    // Output values are derived from the next scan position, so once
    // registered they line up with cnt/dig in the same cycle.
    always_comb begin
        one_hot    = 4'b0001 << dig_next;
        an_next    = AN_OFF;
        seg_next   = SEG_OFF;
        frame_next = 1'b0;

        if (En) begin
            if (!in_blank) begin
                an_next  = ACTIVE_LOW ? ~one_hot : one_hot;
                seg_next = seg_lat_next;
            end
            frame_next = (dig_next == 2'd3) && (cnt_next == CNT_LAST);
        end
    end

    // State and output registers; reset darkens the display immediately.
    always_ff @(posedge Clk or posedge Rst) begin
        if (Rst) begin
            cnt        <= '0;
            dig        <= 2'd0;
            seg_lat    <= 7'd0;
            running    <= 1'b0;
            An         <= AN_OFF;
            Seg        <= SEG_OFF;
            Digit_sel  <= 2'd0;
            Frame_tick <= 1'b0;
        end else begin
            cnt        <= cnt_next;
            dig        <= dig_next;
            seg_lat    <= seg_lat_next;
            running    <= running_next;
            An         <= an_next;
            Seg        <= seg_next;
            Digit_sel  <= dig_next;
            Frame_tick <= frame_next;
        end
    end

endmodule

// File: tb/tb_display_scanner.sv
// ---------------------------------------------------------------------------
// tb_display_scanner
//   Bench for display_scanner. Three instances share the same stimulus:
//     dut 0: SCAN_DIV=8, BLANK_CYCLES=2, ACTIVE_LOW=1
//     dut 1: SCAN_DIV=8, BLANK_CYCLES=0, ACTIVE_LOW=1
//     dut 2: SCAN_DIV=8, BLANK_CYCLES=2, ACTIVE_LOW=0
//   The stimulus side tracks the scan position since the last restart and
//   queues the expected outputs of every instance for the current cycle; a
//   monitor on the falling edge pops and compares them.
// ---------------------------------------------------------------------------
module tb_display_scanner;

    logic       Clk;
    logic       Rst;
    logic       En;
    logic [6:0] Seg0, Seg1, Seg2, Seg3;

    logic [6:0] seg_o   [3];
    logic [3:0] an_o    [3];
    logic [1:0] sel_o   [3];
    logic       ft_o    [3];

    typedef struct {
        int         dut;
        int         phase;
        logic [3:0] an;
        logic [6:0] seg;
        logic [1:0] sel;
        logic       ft;
    } exp_t;

    exp_t       sb[$];
    int         checks = 0;
    int         errors = 0;
    int         phase  = 0;
    int         p      = 0;
    bit         model_run = 1'b0;
    logic [6:0] cur_in [4];
    logic [6:0] lat    [4];

    display_scanner #(.SCAN_DIV(8), .BLANK_CYCLES(2), .ACTIVE_LOW(1'b1)) u_main (
        .Clk(Clk), .Rst(Rst), .En(En),
        .Seg0(Seg0), .Seg1(Seg1), .Seg2(Seg2), .Seg3(Seg3),
        .Seg(seg_o[0]), .An(an_o[0]), .Digit_sel(sel_o[0]), .Frame_tick(ft_o[0])
    );

    display_scanner #(.SCAN_DIV(8), .BLANK_CYCLES(0), .ACTIVE_LOW(1'b1)) u_noblank (
        .Clk(Clk), .Rst(Rst), .En(En),
        .Seg0(Seg0), .Seg1(Seg1), .Seg2(Seg2), .Seg3(Seg3),
        .Seg(seg_o[1]), .An(an_o[1]), .Digit_sel(sel_o[1]), .Frame_tick(ft_o[1])
    );

    display_scanner #(.SCAN_DIV(8), .BLANK_CYCLES(2), .ACTIVE_LOW(1'b0)) u_high (
        .Clk(Clk), .Rst(Rst), .En(En),
        .Seg0(Seg0), .Seg1(Seg1), .Seg2(Seg2), .Seg3(Seg3),
        .Seg(seg_o[2]), .An(an_o[2]), .Digit_sel(sel_o[2]), .Frame_tick(ft_o[2])
    );

    // Free-running clock, period 10.
    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    // Hard time limit so the run always ends.
    initial begin
        #1000000;
        $display("[TB] FAIL watchdog: simulation did not finish, got timeout, required completion");
        $fatal(1, "[TB] watchdog expired");
    end

    function automatic string phase_name(input int ph);
        case (ph)
            0:       return "reset";
            1:       return "scan";
            2:       return "midslot_change";
            3:       return "async_reset";
            default: return "enable_toggle";
        endcase
    endfunction

    function automatic int blank_of(input int d);
        return (d == 1) ? 0 : 2;
    endfunction

    function automatic bit active_low_of(input int d);
        return (d == 2) ? 1'b0 : 1'b1;
    endfunction

    // Drive enable and the four digit patterns.
    task automatic applyStimulus(input logic en_v, input logic [6:0] s0,
                                 input logic [6:0] s1, input logic [6:0] s2,
                                 input logic [6:0] s3);
        En = en_v;
        Seg0 = s0; Seg1 = s1; Seg2 = s2; Seg3 = s3;
        cur_in[0] = s0; cur_in[1] = s1; cur_in[2] = s2; cur_in[3] = s3;
    endtask

    // Queue the expected outputs of instance d for the current cycle.
    task automatic checkOutput(input int d);
        exp_t       e;
        int         slot;
        int         c;
        bit         al;
        logic [3:0] oh;
        al    = active_low_of(d);
        e.dut   = d;
        e.phase = phase;
        e.an    = al ? 4'hF : 4'h0;
        e.seg   = al ? 7'h7F : 7'h00;
        e.sel   = 2'd0;
        e.ft    = 1'b0;
        if (model_run) begin
            slot  = (p / 8) % 4;
            c     = p % 8;
            oh    = 4'b0001 << slot;
            e.sel = slot[1:0];
            e.ft  = ((p % 32) == 31);
            if (c >= blank_of(d)) begin
                e.an  = al ? ~oh : oh;
                e.seg = lat[slot];
            end
        end
        sb.push_back(e);
    endtask

    // Advance one clock and update the position model from what the edge saw.
    task automatic tick_cycle(input bit push_it);
        int slot;
        @(posedge Clk);
        #1;
        if (Rst || !En) begin
            model_run = 1'b0;
        end else if (!model_run) begin
            model_run = 1'b1;
            p = 0;
        end else begin
            p = p + 1;
        end
        if (model_run && ((p % 8) == 0)) begin
            slot = (p / 8) % 4;
            lat[slot] = cur_in[slot];
        end
        if (push_it) begin
            for (int d = 0; d < 3; d++) checkOutput(d);
        end
    endtask

    // Monitor: everything queued since the last falling edge belongs to
    // the current cycle.
    always @(negedge Clk) begin
        exp_t e;
        while (sb.size() > 0) begin
            e = sb.pop_front();
            checks = checks + 1;
            if ((an_o[e.dut] !== e.an) || (seg_o[e.dut] !== e.seg) ||
                (sel_o[e.dut] !== e.sel) || (ft_o[e.dut] !== e.ft)) begin
                errors = errors + 1;
                $display("[TB] FAIL %s dut%0d t=%0t: got An=%b Seg=%h sel=%0d ft=%b, required An=%b Seg=%h sel=%0d ft=%b",
                         phase_name(e.phase), e.dut, $time,
                         an_o[e.dut], seg_o[e.dut], sel_o[e.dut], ft_o[e.dut],
                         e.an, e.seg, e.sel, e.ft);
            end
        end
    end

    initial begin
        Rst = 1'b1;
        applyStimulus(1'b0, 7'h40, 7'h79, 7'h24, 7'h30);
        for (int k = 0; k < 4; k++) lat[k] = 7'h00;

        // Reset held, then idle with En low.
        phase = 0;
        repeat (3) tick_cycle(1'b1);
        Rst = 1'b0;
        repeat (2) tick_cycle(1'b1);

        // Two full frames of normal scanning.
        $display("[TB] enabling scan");
        applyStimulus(1'b1, 7'h40, 7'h79, 7'h24, 7'h30);
        phase = 1;
        repeat (64) tick_cycle(1'b1);

        // Change digit 1 at count 3 of slot 1 (position 75).
        phase = 2;
        repeat (12) tick_cycle(1'b1);
        applyStimulus(1'b1, 7'h40, 7'h12, 7'h24, 7'h30);
        repeat (41) tick_cycle(1'b1);

        // Asynchronous reset at count 5 of slot 2 (position 117), between edges.
        phase = 3;
        tick_cycle(1'b0);
        Rst = 1'b1;
        model_run = 1'b0;
        for (int d = 0; d < 3; d++) checkOutput(d);
        tick_cycle(1'b1);
        Rst = 1'b0;
        repeat (20) tick_cycle(1'b1);

        // Drop enable during slot 2, hold it low past a frame, then restart.
        phase = 4;
        applyStimulus(1'b0, 7'h40, 7'h12, 7'h24, 7'h30);
        repeat (40) tick_cycle(1'b1);
        applyStimulus(1'b1, 7'h40, 7'h12, 7'h24, 7'h30);
        repeat (16) tick_cycle(1'b1);

        @(negedge Clk);
        #1;
        checks = checks + 1;
        if (sb.size() != 0) begin
            errors = errors + 1;
            $display("[TB] FAIL scoreboard_drain: got %0d pending entries, required 0", sb.size());
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
